// File: rtl/perf_pkg.sv
// Shared types, defaults and helpers for the performance counter bank.
package perf_pkg;

  typedef enum logic {PERF_WRAP = 1'b0, PERF_SAT = 1'b1} perf_mode_t;

  localparam int PERF_DEFAULT_WIDTH = 32;
  localparam int PERF_DEFAULT_CH    = 4;

  // A select is never narrower than one bit, even for a single channel.
  function automatic int perf_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_ch.sv
// One event counter channel: clear > load > increment, with wrap or saturate
// behaviour at all-ones and a sticky overflow flag.
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int WIDTH    = PERF_DEFAULT_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam perf_mode_t       MODE     = (SATURATE != 0) ? PERF_SAT : PERF_WRAP;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;

  always_comb begin
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (clear) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (load) begin
      // A load wins over a same-cycle event, which is dropped.
      count_next = load_data;
      ovf_next   = 1'b0;
    end else if (inc) begin
      if (count_reg == ALL_ONES) begin
        ovf_next   = 1'b1;
        count_next = (MODE == PERF_SAT) ? count_reg : '0;
      end else begin
        count_next = count_reg + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH performance counters with a registered one-cycle read port.
// Define PERF_COUNTER_SNAPSHOT_EN to add shadow registers captured by snap.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter  int NUM_CH   = PERF_DEFAULT_CH,
  parameter  int WIDTH    = PERF_DEFAULT_WIDTH,
  parameter  int SATURATE = 0,
  localparam int SEL_W    = perf_sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] inc,
  input  logic              clear_all,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              snap,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] ovf
);

  logic [WIDTH-1:0] count  [NUM_CH];
  logic [WIDTH-1:0] rd_src [NUM_CH];
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic load;
    // Out-of-range selects match no channel, so such loads are ignored.
    assign load = wr_en && (wr_sel == SEL_W'(gi));

    perf_counter_ch #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_all),
      .load      (load),
      .load_data (wr_data),
      .inc       (inc[gi]),
      .count     (count[gi]),
      .ovf       (ovf[gi])
    );

`ifdef PERF_COUNTER_SNAPSHOT_EN
    // Shadows survive clear_all; only reset zeroes them.
    logic [WIDTH-1:0] shadow_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_reg <= '0;
      end else if (snap) begin
        shadow_reg <= count[gi];
      end
    end
    assign rd_src[gi] = shadow_reg;
`else
    assign rd_src[gi] = count[gi];
`endif
  end

`ifndef PERF_COUNTER_SNAPSHOT_EN
  logic unused_snap;
  assign unused_snap = snap;
`endif

  // Unmatched (out-of-range) selects read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_mux = rd_src[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_data_reg <= rd_mux;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: three banks (4-bit wrap, 4-bit saturate, 3-channel 8-bit
// wrap) share one stimulus stream and are checked against a behavioural model.
module tb_perf_counter_bank;

`ifdef PERF_COUNTER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] inc = '0;
  logic       clear_all = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_sel = '0;
  logic       snap = 1'b0;

  logic [3:0] rd_data_w, rd_data_s;
  logic [7:0] rd_data_n;
  logic       rd_valid_w, rd_valid_s, rd_valid_n;
  logic [3:0] ovf_w, ovf_s;
  logic [2:0] ovf_n;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(4), .WIDTH(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .inc(inc), .clear_all(clear_all),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data[3:0]),
    .rd_en(rd_en), .rd_sel(rd_sel), .snap(snap),
    .rd_data(rd_data_w), .rd_valid(rd_valid_w), .ovf(ovf_w));

  perf_counter_bank #(.NUM_CH(4), .WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .inc(inc), .clear_all(clear_all),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data[3:0]),
    .rd_en(rd_en), .rd_sel(rd_sel), .snap(snap),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s), .ovf(ovf_s));

  perf_counter_bank #(.NUM_CH(3), .WIDTH(8), .SATURATE(0)) dut_n (
    .clk(clk), .reset(reset), .inc(inc[2:0]), .clear_all(clear_all),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .snap(snap),
    .rd_data(rd_data_n), .rd_valid(rd_valid_n), .ovf(ovf_n));

  int tests = 0;
  int fails = 0;

  // Behavioural model: plain integer counters per bank and channel.
  int nch  [3] = '{4, 4, 3};
  int maxv [3] = '{15, 15, 255};
  bit sat  [3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt    [3][4];
  int m_shadow [3][4];
  bit m_ovf    [3][4];
  int m_rd_data  [3];
  bit m_rd_valid [3];
  bit live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      m_rd_data[m] = 0;
      m_rd_valid[m] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_cnt[m][c] = 0; m_shadow[m][c] = 0; m_ovf[m][c] = 1'b0;
      end
    end
    forever begin
      @(posedge clk);
      if (reset) begin
        live = 1'b1;
        for (int m = 0; m < 3; m++) begin
          m_rd_data[m] = 0;
          m_rd_valid[m] = 1'b0;
          for (int c = 0; c < 4; c++) begin
            m_cnt[m][c] = 0; m_shadow[m][c] = 0; m_ovf[m][c] = 1'b0;
          end
        end
      end else begin
        for (int m = 0; m < 3; m++) begin
          m_rd_valid[m] = rd_en;
          if (rd_en) begin
            if (int'(rd_sel) >= nch[m]) m_rd_data[m] = 0;
            else if (SNAP) m_rd_data[m] = m_shadow[m][rd_sel];
            else m_rd_data[m] = m_cnt[m][rd_sel];
          end
          if (SNAP && snap)
            for (int c = 0; c < nch[m]; c++) m_shadow[m][c] = m_cnt[m][c];
          for (int c = 0; c < nch[m]; c++) begin
            if (clear_all) begin
              m_cnt[m][c] = 0; m_ovf[m][c] = 1'b0;
            end else if (wr_en && int'(wr_sel) == c) begin
              m_cnt[m][c] = int'(wr_data) % (maxv[m] + 1); m_ovf[m][c] = 1'b0;
            end else if (inc[c]) begin
              if (m_cnt[m][c] == maxv[m]) begin
                m_ovf[m][c] = 1'b1;
                if (!sat[m]) m_cnt[m][c] = 0;
              end else begin
                m_cnt[m][c] = m_cnt[m][c] + 1;
              end
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle once the first reset has been applied.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        for (int m = 0; m < 3; m++) begin
          logic [3:0] eo, ao;
          logic [7:0] ad;
          logic       av;
          eo = '0;
          for (int c = 0; c < nch[m]; c++) eo[c] = m_ovf[m][c];
          case (m)
            0: begin ad = {4'b0, rd_data_w}; av = rd_valid_w; ao = ovf_w; end
            1: begin ad = {4'b0, rd_data_s}; av = rd_valid_s; ao = ovf_s; end
            default: begin ad = rd_data_n; av = rd_valid_n; ao = {1'b0, ovf_n}; end
          endcase
          chk($sformatf("model dut%0d rd_valid", m), 32'(av), 32'(m_rd_valid[m]));
          chk($sformatf("model dut%0d rd_data", m), 32'(ad), 32'(m_rd_data[m]));
          chk($sformatf("model dut%0d ovf", m), 32'(ao), 32'(eo));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inc = '0; clear_all = 1'b0; wr_en = 1'b0; rd_en = 1'b0; snap = 1'b0; reset = 1'b0;
  endtask

  // With shadows enabled, refresh them first so the read shows live state.
  task automatic read_ch(input int s);
    if (SNAP) begin
      snap = 1'b1; tick(); snap = 1'b0;
    end
    rd_en = 1'b1; rd_sel = 2'(s); tick(); rd_en = 1'b0;
    $display("[TB] read ch%0d: w=%0h s=%0h n=%0h", s, rd_data_w, rd_data_s, rd_data_n);
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick();
    idle(); tick(); tick();

    // Reset state read-back on every channel.
    for (int k = 0; k < 4; k++) begin
      read_ch(k);
      chk("reset rd_data", 32'(rd_data_w), 32'd0);
      chk("reset rd_valid", 32'(rd_valid_w), 32'd1);
      chk("reset ovf", 32'(ovf_w), 32'd0);
    end

    // 17 events on channel 1.
    inc = 4'b0010; repeat (17) tick(); idle();
    read_ch(1);
    chk("wrap17 count", 32'(rd_data_w), 32'd1);
    chk("wrap17 ovf", 32'(ovf_w), 32'b0010);
    chk("sat17 count", 32'(rd_data_s), 32'd15);
    chk("sat17 ovf", 32'(ovf_s), 32'b0010);
    chk("wide17 count", 32'(rd_data_n), 32'd17);
    chk("wide17 ovf", 32'(ovf_n), 32'd0);
    read_ch(0);
    chk("wrap17 other ch", 32'(rd_data_w), 32'd0);

    // Reset in the middle of activity discards the read.
    inc = 4'b1111; rd_en = 1'b1; rd_sel = 2'd1; reset = 1'b1;
    tick(); idle();
    chk("midreset rd_valid", 32'(rd_valid_w), 32'd0);
    chk("midreset ovf", 32'(ovf_w), 32'd0);
    chk("midreset rd_data", 32'(rd_data_w), 32'd0);
    read_ch(1);
    chk("midreset count", 32'(rd_data_w), 32'd0);

    // 20 events on channel 0, then load with a coincident event.
    inc = 4'b0001; repeat (20) tick(); idle();
    read_ch(0);
    chk("sat20 count", 32'(rd_data_s), 32'd15);
    chk("sat20 ovf", 32'(ovf_s), 32'b0001);
    chk("wrap20 count", 32'(rd_data_w), 32'd4);
    chk("wide20 count", 32'(rd_data_n), 32'd20);
    wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'd3; inc = 4'b0001;
    tick(); idle();
    read_ch(0);
    chk("load count", 32'(rd_data_s), 32'd3);
    chk("load ovf", 32'(ovf_s), 32'd0);

    // Read coinciding with an increment returns the old value.
    wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'h10; tick(); idle();
    snap = 1'b1; tick(); idle();
    inc = 4'b0100; rd_en = 1'b1; rd_sel = 2'd2; tick(); idle();
    chk("rd old value", 32'(rd_data_n), 32'h10);
    read_ch(2);
    chk("rd new value", 32'(rd_data_n), 32'h11);
    chk("rd new value narrow", 32'(rd_data_w), 32'h1);
    clear_all = 1'b1; inc = 4'b1111; tick(); idle();
    for (int k = 0; k < 4; k++) begin
      read_ch(k);
      chk("clear count", 32'(rd_data_w), 32'd0);
      chk("clear count wide", 32'(rd_data_n), 32'd0);
    end
    chk("clear ovf", 32'(ovf_w), 32'd0);

    // Snapshot sequence on channel 3; also an out-of-range select on dut_n.
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'd7; tick(); idle();
    snap = 1'b1; tick(); idle();
    inc = 4'b1000; repeat (5) tick(); idle();
    rd_en = 1'b1; rd_sel = 2'd3; tick(); idle();
    chk("snapshot read", 32'(rd_data_w), SNAP ? 32'd7 : 32'd12);
    chk("oor rd_data", 32'(rd_data_n), 32'd0);
    chk("oor rd_valid", 32'(rd_valid_n), 32'd1);

    // Randomised traffic, all checked by the compare process.
    for (int i = 0; i < 600; i++) begin
      inc       = 4'($urandom);
      clear_all = ($urandom_range(0, 31) == 0);
      wr_en     = ($urandom_range(0, 7) == 0);
      wr_sel    = 2'($urandom);
      wr_data   = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      rd_en     = $urandom_range(0, 1) == 1;
      rd_sel    = 2'($urandom);
      snap      = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
